// File: rtl/tb_watchdog_pkg.sv
// -----------------------------------------------------------------------------
// tb_watchdog_pkg
// Shared types and constants for the cycle-count watchdog.
//   t_wdg_state           : watchdog state (IDLE, RUN, EXPIRED)
//   C_WDG_DEFAULT_TIMEOUT : limit used when the bench arms with timeout_val == 0
// -----------------------------------------------------------------------------
package tb_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } t_wdg_state;

    localparam int C_WDG_DEFAULT_TIMEOUT = 1000;

endpackage : tb_watchdog_pkg

// File: rtl/tb_watchdog.sv
// -----------------------------------------------------------------------------
// tb_watchdog
// Cycle-count watchdog. Once armed by start it counts clock cycles and flags a
// timeout when the count reaches the captured limit, unless it is kicked
// (count restarts) or stopped first. A saturating tally records timeouts.
//
// Parameters
//   G_CNT_WIDTH       : width of the cycle counter and limit
//   G_DEFAULT_TIMEOUT : limit used when timeout_val is 0 at start
//   G_ERR_WIDTH       : width of the timeout tally
// Ports
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   start         in   arm / re-arm (captures timeout_val)
//   stop          in   disarm (highest priority)
//   kick          in   restart the count while running
//   timeout_val   in   limit in cycles, 0 selects G_DEFAULT_TIMEOUT
//   running       out  high in RUN
//   expired       out  high in EXPIRED (sticky until start/stop)
//   expired_pulse out  one-cycle strobe on entry to EXPIRED
//   cnt           out  current cycle count
//   err_count     out  saturating number of timeouts since reset
// -----------------------------------------------------------------------------
module tb_watchdog
    import tb_watchdog_pkg::*;
#(
    parameter int G_CNT_WIDTH       = 32,
    parameter int G_DEFAULT_TIMEOUT = C_WDG_DEFAULT_TIMEOUT,
    parameter int G_ERR_WIDTH       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   kick,
    input  logic [G_CNT_WIDTH-1:0] timeout_val,
    output logic                   running,
    output logic                   expired,
    output logic                   expired_pulse,
    output logic [G_CNT_WIDTH-1:0] cnt,
    output logic [G_ERR_WIDTH-1:0] err_count
);

    localparam logic [G_CNT_WIDTH-1:0] C_CNT_ZERO  = {G_CNT_WIDTH{1'b0}};
    localparam logic [G_CNT_WIDTH-1:0] C_CNT_ONE   = {{(G_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [G_CNT_WIDTH-1:0] C_DEF_LIMIT = G_CNT_WIDTH'(G_DEFAULT_TIMEOUT);
    localparam logic [G_ERR_WIDTH-1:0] C_ERR_ZERO  = {G_ERR_WIDTH{1'b0}};
    localparam logic [G_ERR_WIDTH-1:0] C_ERR_ONE   = {{(G_ERR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [G_ERR_WIDTH-1:0] C_ERR_MAX   = {G_ERR_WIDTH{1'b1}};

    // Saturating increment of the timeout tally: holds at all-ones.
    function automatic logic [G_ERR_WIDTH-1:0] f_sat_inc(input logic [G_ERR_WIDTH-1:0] val);
        if (val == C_ERR_MAX) begin
            return val;
        end else begin
            return val + C_ERR_ONE;
        end
    endfunction

    t_wdg_state             r_state;
    logic [G_CNT_WIDTH-1:0] r_cnt;
    logic [G_CNT_WIDTH-1:0] r_limit;
    logic [G_ERR_WIDTH-1:0] r_err;
    logic                   r_running;
    logic                   r_expired;
    logic                   r_pulse;

    logic [G_CNT_WIDTH-1:0] w_cnt_inc;
    logic [G_CNT_WIDTH-1:0] w_start_limit;

    // Count increment and the limit that a start on this edge would capture.
    always_comb begin
        w_cnt_inc = r_cnt + C_CNT_ONE;
        if (timeout_val == C_CNT_ZERO) begin
            w_start_limit = C_DEF_LIMIT;
        end else begin
            w_start_limit = timeout_val;
        end
    end

    // Watchdog FSM: state, count, limit, tally and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= C_CNT_ZERO;
            r_limit   <= C_DEF_LIMIT;
            r_err     <= C_ERR_ZERO;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    // stop outranks start; kick has no meaning here
                    if (!stop && start) begin
                        r_state   <= RUN;
                        r_cnt     <= C_CNT_ZERO;
                        r_limit   <= w_start_limit;
                        r_running <= 1'b1;
                        r_expired <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // count freezes at its last value
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end else if (start) begin
                        r_cnt   <= C_CNT_ZERO;
                        r_limit <= w_start_limit;
                    end else if (kick) begin
                        // a kick on the would-be expiry edge prevents expiry
                        r_cnt <= C_CNT_ZERO;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == r_limit) begin
                            r_state   <= EXPIRED;
                            r_running <= 1'b0;
                            r_expired <= 1'b1;
                            r_pulse   <= 1'b1;
                            r_err     <= f_sat_inc(r_err);
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                EXPIRED: begin
                    if (stop) begin
                        r_state   <= IDLE;
                        r_expired <= 1'b0;
                    end else if (start) begin
                        r_state   <= RUN;
                        r_cnt     <= C_CNT_ZERO;
                        r_limit   <= w_start_limit;
                        r_running <= 1'b1;
                        r_expired <= 1'b0;
                    end else begin
                        r_state <= EXPIRED;
                    end
                end
                default: begin
                    // unreachable encoding: fall back to a safe disarmed state
                    r_state   <= IDLE;
                    r_cnt     <= C_CNT_ZERO;
                    r_running <= 1'b0;
                    r_expired <= 1'b0;
                end
            endcase
        end
    end

    assign running       = r_running;
    assign expired       = r_expired;
    assign expired_pulse = r_pulse;
    assign cnt           = r_cnt;
    assign err_count     = r_err;

endmodule : tb_watchdog

// File: tb/tb_tb_watchdog.sv
// -----------------------------------------------------------------------------
// tb_tb_watchdog
// Self-checking bench for tb_watchdog. A reference model tracks the watchdog
// as "mode + cycle at which counting last restarted + limit", derives the
// expected outputs with plain arithmetic, and is compared on every cycle.
// Directed scenarios add literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_tb_watchdog;

    localparam int CW  = 16;
    localparam int DEF = 20;
    localparam int EW  = 2;
    localparam int ERR_MAX = 3;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          kick;
    logic [CW-1:0] timeout_val;
    logic          running;
    logic          expired;
    logic          expired_pulse;
    logic [CW-1:0] cnt;
    logic [EW-1:0] err_count;

    tb_watchdog #(
        .G_CNT_WIDTH      (CW),
        .G_DEFAULT_TIMEOUT(DEF),
        .G_ERR_WIDTH      (EW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .kick         (kick),
        .timeout_val  (timeout_val),
        .running      (running),
        .expired      (expired),
        .expired_pulse(expired_pulse),
        .cnt          (cnt),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model
    int edge_no;     // number of model-visible rising edges so far
    int m_mode;
    int m_origin;    // edge after which the count was last 0
    int m_limit;
    int m_frozen;    // count shown while idle
    int m_err;
    int m_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_origin = edge_no;
        m_limit  = DEF;
        m_frozen = 0;
        m_err    = 0;
        m_pulse  = 0;
    endtask

    function automatic int model_cnt();
        if (m_mode == M_RUN)      return edge_no - m_origin;
        else if (m_mode == M_EXP) return m_limit;
        else                      return m_frozen;
    endfunction

    task automatic model_edge(input bit st, input bit sp, input bit kk, input int tv);
        m_pulse = 0;
        if (sp) begin
            if (m_mode == M_RUN)      m_frozen = (edge_no - 1) - m_origin;
            else if (m_mode == M_EXP) m_frozen = m_limit;
            m_mode = M_IDLE;
        end else if (st) begin
            m_mode   = M_RUN;
            m_origin = edge_no;
            m_limit  = (tv == 0) ? DEF : tv;
        end else if (m_mode == M_RUN) begin
            if (kk) begin
                m_origin = edge_no;
            end else if (edge_no - m_origin == m_limit) begin
                m_mode  = M_EXP;
                m_pulse = 1;
                if (m_err < ERR_MAX) m_err++;
            end
        end
    endtask

    task automatic compare_all();
        chk("running",       32'(running),       32'(m_mode == M_RUN));
        chk("expired",       32'(expired),       32'(m_mode == M_EXP));
        chk("expired_pulse", 32'(expired_pulse), 32'(m_pulse));
        chk("cnt",           32'(cnt),           32'(model_cnt()));
        chk("err_count",     32'(err_count),     32'(m_err));
    endtask

    // One clock cycle: drive on the falling edge, model on the rising edge,
    // compare just after it.
    task automatic step(input bit st, input bit sp, input bit kk, input int tv);
        @(negedge clk);
        start       = st;
        stop        = sp;
        kick        = kk;
        timeout_val = CW'(tv);
        @(posedge clk);
        edge_no++;
        model_edge(st, sp, kk, tv);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 7);
    endtask

    // Reset pulse placed strictly between rising edges; outputs must clear
    // without any edge.
    task automatic async_reset();
        @(negedge clk);
        start = 1'b0; stop = 1'b0; kick = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; kick = 1'b0;
        timeout_val = '0;
        edge_no = 0;
        model_reset();

        // reset state
        async_reset();
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_cnt",     32'(cnt),     32'd0);
        chk("reset_err",     32'(err_count), 32'd0);

        // limit 5, no kicks
        step(1'b1, 1'b0, 1'b0, 5);
        chk("t1_cnt0", 32'(cnt), 32'd0);
        chk("t1_run0", 32'(running), 32'd1);
        idle(4);
        chk("t1_not_yet", 32'(expired), 32'd0);
        idle(1);
        chk("t1_expired", 32'(expired), 32'd1);
        chk("t1_pulse",   32'(expired_pulse), 32'd1);
        chk("t1_cnt",     32'(cnt), 32'd5);
        chk("t1_err",     32'(err_count), 32'd1);
        idle(1);
        chk("t1_pulse_w", 32'(expired_pulse), 32'd0);
        chk("t1_sticky",  32'(expired), 32'd1);

        // limit 10, kicks at t0+4 and t0+8 -> expiry at t0+18
        async_reset();
        step(1'b1, 1'b0, 1'b0, 10);
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, 1'b0, (k == 4 || k == 8), 3);
            if (k == 17) chk("t2_not_yet", 32'(expired), 32'd0);
        end
        chk("t2_expired", 32'(expired), 32'd1);
        chk("t2_err",     32'(err_count), 32'd1);

        // kick on the would-be expiry edge, limit 3
        async_reset();
        step(1'b1, 1'b0, 1'b0, 3);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 0);
        chk("t3_cnt",     32'(cnt), 32'd0);
        chk("t3_running", 32'(running), 32'd1);
        chk("t3_expired", 32'(expired), 32'd0);

        // default limit, then re-arm from EXPIRED with limit 2
        async_reset();
        step(1'b1, 1'b0, 1'b0, 0);
        idle(19);
        chk("t4_not_yet", 32'(expired), 32'd0);
        idle(1);
        chk("t4_expired", 32'(expired), 32'd1);
        chk("t4_cnt",     32'(cnt), 32'd20);
        step(1'b1, 1'b0, 1'b0, 2);
        idle(2);
        chk("t4_re_exp", 32'(expired), 32'd1);
        chk("t4_err",    32'(err_count), 32'd2);

        // stop and start together while running
        async_reset();
        step(1'b1, 1'b0, 1'b0, 10);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 4);
        chk("t5_running", 32'(running), 32'd0);
        chk("t5_cnt",     32'(cnt), 32'd3);
        idle(2);
        chk("t5_frozen",  32'(cnt), 32'd3);

        // asynchronous reset mid-run
        async_reset();
        step(1'b1, 1'b0, 1'b0, 10);
        idle(4);
        async_reset();
        chk("t6_running", 32'(running), 32'd0);
        chk("t6_cnt",     32'(cnt), 32'd0);

        // five timeouts with a 2-bit tally
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1);
            idle(1);
        end
        chk("t7_sat", 32'(err_count), 32'd3);

        // randomized phase
        async_reset();
        for (int i = 0; i < 4000; i++) begin
            int r_sp, r_st, r_kk, r_tv;
            if ($urandom_range(0, 999) < 3) async_reset();
            r_sp = ($urandom_range(0, 99) < 4)  ? 1 : 0;
            r_st = ($urandom_range(0, 99) < 7)  ? 1 : 0;
            r_kk = ($urandom_range(0, 99) < 10) ? 1 : 0;
            r_tv = $urandom_range(0, 15);
            step(r_st[0], r_sp[0], r_kk[0], r_tv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_tb_watchdog
